// File: rtl/inv_iter_pkg.sv
// rtl/inv_iter_pkg.sv - shared types and sizing helpers for the iterative modular inverter
package inv_iter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int IP_WIDTH_DEFAULT = 6;
    localparam int T_W              = IP_WIDTH_DEFAULT + 2;

    // Bezout coefficients stay within [-m, m], so two extra bits cover sign and magnitude.
    function automatic int t_width(input int ip_width);
        return ip_width + 2;
    endfunction

    // Euclid needs at most ~1.45*w quotient steps; the counter must reach that plus margin.
    function automatic int min_cnt_w(input int ip_width);
        int steps;
        steps = (145 * ip_width + 99) / 100 + 2;
        return $clog2(steps + 1);
    endfunction

endpackage

// File: rtl/inv_iter_if.sv
// rtl/inv_iter_if.sv - request/result handshake bundle; INV_ITER_CNT_EN adds out_iter
interface inv_iter_if #(
    parameter int IP_WIDTH = 6
`ifdef INV_ITER_CNT_EN
    , parameter int CNT_W  = 5
`endif
);
    logic                in_valid;
    logic                in_ready;
    logic [IP_WIDTH-1:0] in_val;
    logic [IP_WIDTH-1:0] in_mod;
    logic                out_valid;
    logic                out_ready;
    logic [IP_WIDTH-1:0] out_inv;
    logic                out_err;
`ifdef INV_ITER_CNT_EN
    logic [CNT_W-1:0]    out_iter;
`endif

    modport master (
        output in_valid, in_val, in_mod, out_ready,
        input  in_ready, out_valid, out_inv, out_err
`ifdef INV_ITER_CNT_EN
        , input out_iter
`endif
    );

    modport slave (
        input  in_valid, in_val, in_mod, out_ready,
        output in_ready, out_valid, out_inv, out_err
`ifdef INV_ITER_CNT_EN
        , output out_iter
`endif
    );

endinterface

// File: rtl/inv_step.sv
// rtl/inv_step.sv - one combinational extended-Euclid quotient step
module inv_step #(
    parameter  int IP_WIDTH = 6,
    localparam int TW       = IP_WIDTH + 2
) (
    input  logic [IP_WIDTH-1:0]  r0,
    input  logic [IP_WIDTH-1:0]  r1,
    input  logic signed [TW-1:0] t0,
    input  logic signed [TW-1:0] t1,
    output logic [IP_WIDTH-1:0]  r0_next,
    output logic [IP_WIDTH-1:0]  r1_next,
    output logic signed [TW-1:0] t0_next,
    output logic signed [TW-1:0] t1_next
);

    logic [IP_WIDTH-1:0]              q;
    logic signed [IP_WIDTH+TW-1:0]    tq;
    logic signed [IP_WIDTH+TW-1:0]    tn;

    always_comb begin
        q       = (r1 != '0) ? (r0 / r1) : '0;
        r0_next = r1;
        // q*r1 <= r0, so the narrow product and difference are exact
        r1_next = r0 - q * r1;
        tq      = $signed({{TW{1'b0}}, q}) * $signed({{IP_WIDTH{t1[TW-1]}}, t1});
        tn      = $signed({{IP_WIDTH{t0[TW-1]}}, t0}) - tq;
        t0_next = t1;
        t1_next = TW'(tn);
    end

endmodule

// File: rtl/inv_iter_ip.sv
// rtl/inv_iter_ip.sv - sequential modular inverse (one Euclid step/clock); INV_ITER_CNT_EN exports step count
module inv_iter_ip
    import inv_iter_pkg::*;
#(
    parameter int IP_WIDTH = 6,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    inv_iter_if.slave  bus
);

    localparam int TW = t_width(IP_WIDTH);

    if (CNT_W < min_cnt_w(IP_WIDTH)) begin : g_cnt_w_check
        $error("inv_iter_ip: CNT_W too small for IP_WIDTH");
    end

    state_t                state, state_next;
    logic [IP_WIDTH-1:0]   x_q, m_q, r0, r1, inv_q, inv_fix;
    logic signed [TW-1:0]  t0, t1, t_adj;
    logic                  err_q;
    logic [IP_WIDTH-1:0]   r0_n, r1_n;
    logic signed [TW-1:0]  t0_n, t1_n;

    inv_step #(.IP_WIDTH(IP_WIDTH)) u_step (
        .r0      (r0),
        .r1      (r1),
        .t0      (t0),
        .t1      (t1),
        .r0_next (r0_n),
        .r1_next (r1_n),
        .t0_next (t0_n),
        .t1_next (t1_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_next = LOAD;
            LOAD:    state_next = ITER;
            ITER:    if (r1 == '0)      state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        t_adj   = t0[TW-1] ? (t0 + $signed({2'b00, m_q})) : t0;
        inv_fix = IP_WIDTH'(t_adj);
    end

`ifdef INV_ITER_CNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         cnt <= '0;
        else if (state == LOAD)             cnt <= '0;
        else if (state == ITER && r1 != '0) cnt <= cnt + CNT_W'(1);
    end

    assign bus.out_iter = cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            m_q   <= '0;
            r0    <= '0;
            r1    <= '0;
            t0    <= '0;
            t1    <= '0;
            inv_q <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    x_q <= bus.in_val;
                    m_q <= bus.in_mod;
                end
                LOAD: begin
                    t0 <= '0;
                    t1 <= TW'(1);
                    // m<2 runs a single empty ITER cycle with r0=0, which resolves to an error
                    if (m_q < IP_WIDTH'(2)) begin
                        r0 <= '0;
                        r1 <= '0;
                    end else begin
                        r0 <= m_q;
                        r1 <= x_q % m_q;
                    end
                end
                ITER: begin
                    if (r1 != '0) begin
                        r0 <= r0_n;
                        r1 <= r1_n;
                        t0 <= t0_n;
                        t1 <= t1_n;
                    end else if (r0 == IP_WIDTH'(1)) begin
                        inv_q <= inv_fix;
                        err_q <= 1'b0;
                    end else begin
                        inv_q <= '0;
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_inv   = inv_q;
    assign bus.out_err   = err_q;

endmodule
